// File: rtl/block_accum_pkg.sv
// Shared definitions for the block accumulator: controller states,
// default parameter values and the input sample width.
package block_accum_pkg;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   localparam int BLOCK_LEN_DEF = 4;
   localparam int ACC_W_DEF     = 10;
   localparam int DIN_W         = 9;

endpackage

// File: rtl/block_accum_if.sv
// Sample-in / block-sum-out handshake bundle for block_accum.
// master = upstream/downstream environment, slave = the accumulator.
interface block_accum_if
   import block_accum_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
);

   logic             in_valid;
   logic             in_ready;
   logic [DIN_W-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_data;
   logic             out_ovf;

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_ovf
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_ovf
   );

endinterface

// File: rtl/block_accum_sat_add.sv
// sat_add: adds a signed DIN_W-bit sample to a signed ACC_W-bit running sum
// and flags overflow of the ACC_W-bit result.
// Macro BLOCK_ACCUM_SAT_EN: clamp to the signed range on overflow;
// otherwise the result wraps (two's complement low ACC_W bits).
module sat_add
   import block_accum_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic [ACC_W-1:0] a,
   input  logic [DIN_W-1:0] b,
   output logic [ACC_W-1:0] sum,
   output logic             ovf
);

   localparam logic [ACC_W-1:0] MAX_VAL = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] MIN_VAL = {1'b1, {(ACC_W-1){1'b0}}};

   logic [ACC_W:0] sum_ext;

   // One guard bit wide add; overflow when the guard and sign bits disagree
   always_comb begin
      sum_ext = {a[ACC_W-1], a} + {{(ACC_W+1-DIN_W){b[DIN_W-1]}}, b};
      ovf     = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
      sum     = sum_ext[ACC_W-1:0];
`ifdef BLOCK_ACCUM_SAT_EN
      if (ovf) begin
         sum = sum_ext[ACC_W] ? MIN_VAL : MAX_VAL;
      end
`endif
   end

endmodule

// File: rtl/block_accum.sv
// block_accum: sums BLOCK_LEN signed samples into one ACC_W-bit block sum,
// presents it with a sticky overflow flag and holds it until taken.
// Macro BLOCK_ACCUM_SAT_EN (in sat_add) selects saturating instead of wrapping adds.
module block_accum
   import block_accum_pkg::*;
#(
   parameter int BLOCK_LEN = BLOCK_LEN_DEF,
   parameter int ACC_W     = ACC_W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   block_accum_if.slave bus
);

   localparam int               CNT_W = $clog2(BLOCK_LEN) + 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(BLOCK_LEN - 1);

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             ovf_flag;
   logic             in_ready_r;
   logic             out_valid_r;

   logic [ACC_W-1:0] add_sum;
   logic             add_ovf;

   sat_add #(
      .ACC_W(ACC_W)
   ) u_sat_add (
      .a  (acc),
      .b  (bus.in_data),
      .sum(add_sum),
      .ovf(add_ovf)
   );

   // Accumulate / hold controller with registered handshake outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ACCUM;
         acc         <= '0;
         cnt         <= '0;
         ovf_flag    <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (bus.in_valid) begin
                  acc      <= add_sum;
                  ovf_flag <= ovf_flag | add_ovf;
                  cnt      <= cnt + CNT_W'(1);
                  if (cnt == LAST) begin
                     state       <= HOLD;
                     in_ready_r  <= 1'b0;
                     out_valid_r <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  state       <= ACCUM;
                  acc         <= '0;
                  cnt         <= '0;
                  ovf_flag    <= 1'b0;
                  in_ready_r  <= 1'b1;
                  out_valid_r <= 1'b0;
               end
            end
            default: begin
               state       <= ACCUM;
               acc         <= '0;
               cnt         <= '0;
               ovf_flag    <= 1'b0;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = acc;
   assign bus.out_ovf   = ovf_flag;

endmodule

// File: doc/block_accum.md
BLOCK_ACCUM -- requirements
Module: block_accum

Interface
REQ-001 Parameter BLOCK_LEN, default 4, is the number of samples summed per output block; legal range 2..64.
REQ-002 Parameter ACC_W, default 10, is the accumulator and output width in bits; legal range 9..16.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  in_data carries a valid sample this cycle.
REQ-006 in_ready  output  1  block accepts a sample this cycle.
REQ-007 in_data  input  9  signed sample, i.e. the 9-bit signed select-stage result.
REQ-008 out_valid  output  1  block sum available on out_data.
REQ-009 out_ready  input  1  downstream accepts the block sum this cycle.
REQ-010 out_data  output  ACC_W  signed block sum.
REQ-011 out_ovf  output  1  at least one add in this block overflowed ACC_W.

Function
REQ-012 The block SHALL have two states: ACCUM and HOLD.
REQ-013 In ACCUM:
- in_ready SHALL be 1 and out_valid SHALL be 0.
- A sample is accepted when in_valid and in_ready are both 1.
REQ-014 Each accepted sample SHALL update the accumulator and the sample count.
- in_data is sign-extended to ACC_W+1 bits and added to the sign-extended accumulator.
- The sample count increments by 1.
REQ-015 Overflow SHALL be detected when bits ACC_W and ACC_W-1 of the (ACC_W+1)-bit sum differ; detection sets the block's sticky ovf flag.
REQ-016 When the accepted sample is number BLOCK_LEN:
- The state SHALL move to HOLD on that same edge.
- out_valid SHALL be 1 in the next cycle, so latency from the last acceptance is 1 cycle.
REQ-017 In HOLD:
- in_ready SHALL be 0.
- out_data and out_ovf SHALL remain stable while out_ready is 0.
REQ-018 On the HOLD cycle with out_ready=1:
- The block SHALL return to ACCUM.
- Accumulator, count and ovf flag clear to 0.
- No sample is accepted in that cycle.
REQ-019 A cycle with in_valid=0 in ACCUM SHALL leave all state unchanged; gaps between samples are unlimited.
REQ-020 in_data SHALL be ignored whenever in_ready=0.
REQ-021 The count SHALL be $clog2(BLOCK_LEN)+1 bits wide and SHALL never exceed BLOCK_LEN.

Reset
REQ-022 While rst=1, regardless of clk, the block SHALL hold:
- State = ACCUM, accumulator = 0, count = 0, ovf flag = 0.
- out_valid = 0, out_data = 0, out_ovf = 0, in_ready = 1.
REQ-023 Reset asserted mid-block or during HOLD SHALL discard the partial or pending sum.
REQ-024 The first block after reset release SHALL start from sample 1.

Configuration
REQ-025 With macro BLOCK_ACCUM_SAT_EN defined, an overflowing add SHALL clamp the accumulator:
- to 2^(ACC_W-1)-1 on positive overflow;
- to -2^(ACC_W-1) on negative overflow.
REQ-026 Without BLOCK_ACCUM_SAT_EN, an overflowing add SHALL wrap to the low ACC_W bits (two's complement).
REQ-027 out_ovf SHALL be reported identically with or without BLOCK_ACCUM_SAT_EN.

Structure
REQ-028 Shared package block_accum_pkg SHALL hold:
- the state enumeration (ACCUM, HOLD);
- default constants BLOCK_LEN_DEF=4 and ACC_W_DEF=10;
- the input sample width constant DIN_W=9.
REQ-029 Sub-module sat_add SHALL implement the ACC_W-bit signed add with overflow flag and optional clamp. It is controlled by BLOCK_ACCUM_SAT_EN and is instantiated once.

Verification (BLOCK_LEN=4, ACC_W=10)
REQ-030 Basic sum: samples 10, 20, -5, 1 on consecutive cycles with out_ready=1 -> out_data=26 and out_ovf=0 one cycle after the 4th sample, out_valid high for 1 cycle.
REQ-031 Positive overflow: four samples of 255 ->
- with SAT_EN: out_data=511, out_ovf=1;
- without SAT_EN: out_data=-4 (1020 wrapped), out_ovf=1.
REQ-032 Negative overflow: four samples of -256 ->
- with SAT_EN: out_data=-512, out_ovf=1;
- without SAT_EN: out_data=0, out_ovf=1.
REQ-033 Backpressure: block completes with out_ready=0 for 5 cycles ->
- in_ready=0 and out_data stable for all 5 cycles;
- in_valid samples offered meanwhile are not counted;
- the next block sums correctly after release.
REQ-034 Input gaps: samples 1, 2, 3, 4 with 3 idle cycles between each -> out_data=10.
REQ-035 Mid-block reset: samples 100, 100, then rst pulsed asynchronously between edges ->
- outputs are 0 immediately;
- next block 1, 1, 1, 1 gives out_data=4, out_ovf=0.
